trng_entropy_collector: RTL

Upstream stage of the TRNG conditioning datapath. It samples a raw 1-bit noise source and packs consecutive accepted samples into a 512-bit block. It applies an online repetition-count health test to the samples. It hands each healthy block to the conditioner's 512-bit `data_in` through a valid/ready handshake; the controller starts conditioning with `TRNG_Go`.

---
 rtl/trng_pkg.sv | 16 +
 rtl/trng_entropy_collector_rct.sv | 46 ++++
 rtl/trng_entropy_collector.sv | 100 ++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG entropy collector.
// Optional RCT health monitor is built only when TRNG_RCT_EN is defined.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'h0,
    ST_COLLECT = 2'h1,
    ST_FULL    = 2'h2,
    ST_FAIL    = 2'h3
  } trng_state_e;

  localparam int TRNG_BLOCK_WIDTH = 512;
  localparam int TRNG_CNT_WIDTH   = 10;
  localparam int TRNG_RCT_CUTOFF  = 32;

endpackage

// File: rtl/trng_entropy_collector_rct.sv
// Repetition-count monitor: flags a run of identical samples.
// Present in the collector only when TRNG_RCT_EN is defined.
module trng_rct_monitor
  import trng_pkg::*;
#(
  parameter int P_RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
  input  logic clk,
  input  logic Resetn,
  input  logic clear,
  input  logic sample,
  input  logic sample_valid,
  output logic fail
);

  localparam logic [7:0] Cut = 8'(P_RCT_CUTOFF);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       prev_q;

  // next run length; a zero count marks the first sample of a block
  always_comb begin
    cnt_d = 8'd1;
    if (cnt_q != 8'd0 && sample == prev_q) begin
      cnt_d = (cnt_q == Cut) ? cnt_q : cnt_q + 8'd1;
    end
  end

  assign fail = sample_valid && (cnt_d == Cut);

  // run counter and previous-sample register
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else if (sample_valid) begin
      cnt_q  <= cnt_d;
      prev_q <= sample;
    end
  end

endmodule

// File: rtl/trng_entropy_collector.sv
// Packs accepted noise samples MSB-first into a block and hands it off.
// Define TRNG_RCT_EN to include the repetition-count health test.
module trng_entropy_collector
  import trng_pkg::*;
#(
  parameter int P_BLOCK_WIDTH = TRNG_BLOCK_WIDTH,
  parameter int P_CNT_WIDTH   = TRNG_CNT_WIDTH,
  parameter int P_RCT_CUTOFF  = TRNG_RCT_CUTOFF
) (
  input  logic                     clk,
  input  logic                     Resetn,
  input  logic                     Collect_Go,
  input  logic                     noise_bit,
  input  logic                     noise_valid,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [P_BLOCK_WIDTH-1:0] data_out,
  output logic                     health_fail,
  output logic                     busy
);

  localparam logic [P_CNT_WIDTH-1:0] CntLast =
    P_CNT_WIDTH'(P_BLOCK_WIDTH - 1);

  trng_state_e              state_q;
  trng_state_e              state_d;
  logic [P_BLOCK_WIDTH-1:0] data_q;
  logic [P_CNT_WIDTH-1:0]   cnt_q;
  logic                     start;
  logic                     take;
  logic                     rct_fail;

  assign take = (state_q == ST_COLLECT) && noise_valid;

`ifdef TRNG_RCT_EN
  trng_rct_monitor #(
    .P_RCT_CUTOFF(P_RCT_CUTOFF)
  ) u_rct (
    .clk         (clk),
    .Resetn      (Resetn),
    .clear       (start),
    .sample      (noise_bit),
    .sample_valid(take),
    .fail        (rct_fail)
  );
`else
  // monitor removed; legal cutoffs are >= 2 so this ties to 0
  assign rct_fail = (P_RCT_CUTOFF < 2);
`endif

  // state register
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next state; start marks entry into COLLECT
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (Collect_Go) begin
          state_d = ST_COLLECT;
          start   = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (noise_valid) begin
          if (rct_fail)            state_d = ST_FAIL;
          else if (cnt_q == CntLast) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (blk_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // shift register and sample counter; a failing block is wiped
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= cnt_q + P_CNT_WIDTH'(1);
      if (rct_fail) data_q <= '0;
      else data_q <= {data_q[P_BLOCK_WIDTH-2:0], noise_bit};
    end
  end

  assign data_out    = data_q;
  assign blk_valid   = (state_q == ST_FULL);
  assign health_fail = (state_q == ST_FAIL);
  assign busy        = (state_q == ST_COLLECT);

endmodule
